// File: rtl/whack_pkg.sv
// ============================================================================
// whack_pkg : shared mole count, state encoding and one-hot decode
// Rev 1.0
// ============================================================================
`default_nettype none

package whack_pkg;

    localparam int NUM_MOLES = 8;
    localparam int MOLE_W    = 3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PICK = 3'd1,
        ST_SHOW = 3'd2,
        ST_GAP  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    function automatic logic [NUM_MOLES-1:0] onehot(input logic [MOLE_W-1:0] idx);
        logic [NUM_MOLES-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mole_timer.sv
// ============================================================================
// mole_timer : loadable down-counter, expired while the count sits at zero
// Rev 1.0
// ============================================================================
`default_nettype none

module mole_timer #(
    parameter int WIDTH = 8
) (
    input  logic             i_Clk,
    input  logic             i_Rst_n,
    input  logic             i_Load,
    input  logic [WIDTH-1:0] i_Value,
    output logic             o_Expired
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (i_Load) begin
            count_d = i_Value;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_Expired = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/mole_scheduler.sv
// ============================================================================
// mole_scheduler : whack-a-mole round sequencer (pick, show, judge, score)
// Rev 1.0
// ============================================================================
`default_nettype none

module mole_scheduler
    import whack_pkg::*;
#(
    parameter int SHOW_CYCLES = 25000000,
    parameter int GAP_CYCLES  = 5000000,
    parameter int NUM_ROUNDS  = 16,
    parameter int MAX_RETRY   = 3,
    parameter int SCORE_W     = 5
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst_n,
    input  logic                 i_Start,
    input  logic [MOLE_W-1:0]    i_Rand,
    input  logic [NUM_MOLES-1:0] i_Hit,
    output logic [NUM_MOLES-1:0] o_Mole,
    output logic                 o_Hit_Pulse,
    output logic                 o_Miss_Pulse,
    output logic [SCORE_W-1:0]   o_Score,
    output logic [SCORE_W-1:0]   o_Misses,
    output logic                 o_Busy,
    output logic                 o_Done
);

    localparam int TMR_MAX = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
    localparam int TMR_W   = (TMR_MAX > 2) ? $clog2(TMR_MAX) : 1;
    localparam int RND_W   = (NUM_ROUNDS > 2) ? $clog2(NUM_ROUNDS) : 1;
    localparam int RTY_W   = (MAX_RETRY > 1) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

    state_t                 state_q, state_d;
    logic [MOLE_W-1:0]      last_q, last_d;
    logic                   first_q, first_d;
    logic [RND_W-1:0]       round_q, round_d;
    logic [RTY_W-1:0]       retry_q, retry_d;
    logic [SCORE_W-1:0]     score_q, score_d;
    logic [SCORE_W-1:0]     misses_q, misses_d;
    logic [NUM_MOLES-1:0]   mole_q, mole_d;
    logic                   hit_pulse_q, hit_pulse_d;
    logic                   miss_pulse_q, miss_pulse_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic                   tmr_load;
    logic [TMR_W-1:0]       tmr_value;
    logic                   tmr_expired;
    logic                   accept;
    logic [MOLE_W-1:0]      pick_idx;
    logic                   hit_now;
    logic                   miss_now;

    mole_timer #(
        .WIDTH (TMR_W)
    ) u_timer (
        .i_Clk     (i_Clk),
        .i_Rst_n   (i_Rst_n),
        .i_Load    (tmr_load),
        .i_Value   (tmr_value),
        .o_Expired (tmr_expired)
    );

    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        first_d      = first_q;
        round_d      = round_q;
        retry_d      = retry_q;
        score_d      = score_q;
        misses_d     = misses_q;
        hit_pulse_d  = 1'b0;
        miss_pulse_d = 1'b0;
        tmr_load     = 1'b0;
        tmr_value    = '0;
        accept       = 1'b0;
        pick_idx     = i_Rand;
        hit_now      = 1'b0;
        miss_now     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_Start) begin
                    score_d  = '0;
                    misses_d = '0;
                    round_d  = '0;
                    retry_d  = '0;
                    first_d  = 1'b1;
                    state_d  = ST_PICK;
                end
            end
            ST_PICK: begin
                if (first_q || (i_Rand != last_q)) begin
                    accept = 1'b1;
                end else if (retry_q == RTY_W'(MAX_RETRY)) begin
                    // Forced pick steps to the neighbour; 3-bit add wraps 7 to 0
                    accept   = 1'b1;
                    pick_idx = last_q + 1'b1;
                end else begin
                    retry_d = retry_q + 1'b1;
                end
                if (accept) begin
                    last_d    = pick_idx;
                    first_d   = 1'b0;
                    retry_d   = '0;
                    tmr_load  = 1'b1;
                    tmr_value = TMR_W'(SHOW_CYCLES - 1);
                    state_d   = ST_SHOW;
                end
            end
            ST_SHOW: begin
                if (i_Hit[last_q]) begin
                    hit_now = 1'b1;
                end else if ((i_Hit != '0) || tmr_expired) begin
                    miss_now = 1'b1;
                end
                if (hit_now) begin
                    hit_pulse_d = 1'b1;
                    score_d     = (score_q == SCORE_MAX) ? score_q : score_q + 1'b1;
                end
                if (miss_now) begin
                    miss_pulse_d = 1'b1;
                    misses_d     = (misses_q == SCORE_MAX) ? misses_q : misses_q + 1'b1;
                end
                if (hit_now || miss_now) begin
                    tmr_load  = 1'b1;
                    tmr_value = TMR_W'(GAP_CYCLES - 1);
                    state_d   = ST_GAP;
                end
            end
            ST_GAP: begin
                if (tmr_expired) begin
                    if (round_q == RND_W'(NUM_ROUNDS - 1)) begin
                        state_d = ST_DONE;
                    end else begin
                        round_d = round_q + 1'b1;
                        state_d = ST_PICK;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Registered outputs follow the next state so they align with it
        mole_d = (state_d == ST_SHOW) ? onehot(last_d) : '0;
        busy_d = (state_d != ST_IDLE);
        done_d = (state_q == ST_DONE);
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q      <= ST_IDLE;
            last_q       <= '0;
            first_q      <= 1'b1;
            round_q      <= '0;
            retry_q      <= '0;
            score_q      <= '0;
            misses_q     <= '0;
            mole_q       <= '0;
            hit_pulse_q  <= 1'b0;
            miss_pulse_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            first_q      <= first_d;
            round_q      <= round_d;
            retry_q      <= retry_d;
            score_q      <= score_d;
            misses_q     <= misses_d;
            mole_q       <= mole_d;
            hit_pulse_q  <= hit_pulse_d;
            miss_pulse_q <= miss_pulse_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign o_Mole       = mole_q;
    assign o_Hit_Pulse  = hit_pulse_q;
    assign o_Miss_Pulse = miss_pulse_q;
    assign o_Score      = score_q;
    assign o_Misses     = misses_q;
    assign o_Busy       = busy_q;
    assign o_Done       = done_q;

endmodule

`default_nettype wire

// File: tb/tb_mole_scheduler.sv
// ============================================================================
// tb_mole_scheduler : directed and randomized rounds against a round-level model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mole_scheduler;

    localparam int SHOW_CYCLES = 8;
    localparam int GAP_CYCLES  = 4;
    localparam int NUM_ROUNDS  = 4;
    localparam int MAX_RETRY   = 3;
    localparam int SCORE_W     = 5;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_Start;
    logic [2:0] i_Rand;
    logic [7:0] i_Hit;
    logic [7:0] o_Mole;
    logic       o_Hit_Pulse;
    logic       o_Miss_Pulse;
    logic [SCORE_W-1:0] o_Score;
    logic [SCORE_W-1:0] o_Misses;
    logic       o_Busy;
    logic       o_Done;

    int checks = 0;
    int errors = 0;

    // Round-level model state
    logic [2:0] m_last;
    bit         m_first;
    int         m_score;
    int         m_misses;

    mole_scheduler #(
        .SHOW_CYCLES (SHOW_CYCLES),
        .GAP_CYCLES  (GAP_CYCLES),
        .NUM_ROUNDS  (NUM_ROUNDS),
        .MAX_RETRY   (MAX_RETRY),
        .SCORE_W     (SCORE_W)
    ) dut (
        .i_Clk        (clk),
        .i_Rst_n      (rst_n),
        .i_Start      (i_Start),
        .i_Rand       (i_Rand),
        .i_Hit        (i_Hit),
        .o_Mole       (o_Mole),
        .o_Hit_Pulse  (o_Hit_Pulse),
        .o_Miss_Pulse (o_Miss_Pulse),
        .o_Score      (o_Score),
        .o_Misses     (o_Misses),
        .o_Busy       (o_Busy),
        .o_Done       (o_Done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mole"}, 32'(o_Mole), 32'h0);
        chk({tag, "_hitp"}, 32'(o_Hit_Pulse), 32'h0);
        chk({tag, "_missp"}, 32'(o_Miss_Pulse), 32'h0);
        chk({tag, "_score"}, 32'(o_Score), 32'h0);
        chk({tag, "_misses"}, 32'(o_Misses), 32'h0);
        chk({tag, "_busy"}, 32'(o_Busy), 32'h0);
        chk({tag, "_done"}, 32'(o_Done), 32'h0);
    endtask

    // Called at an IDLE negedge; returns at the first PICK negedge
    task automatic start_game();
        i_Start = 1'b1;
        tick();
        i_Start  = 1'b0;
        m_score  = 0;
        m_misses = 0;
        m_first  = 1'b1;
    endtask

    // rmode 0: hold rhold in PICK, 1: random (often equal to last).
    // pkind 0 none, 1 correct, 2 wrong only, 3 correct plus noise, 4 explicit pval
    task automatic do_round(input int rmode, input logic [2:0] rhold, input int pkind,
                            input int pcyc, input logic [7:0] pval, input bit is_last);
        logic [2:0] r;
        logic [2:0] pick;
        logic [7:0] mole_x;
        logic [7:0] hv;
        int         retry;
        bit         acc;
        bit         outcome;
        bit         was_hit;

        retry = 0;
        acc   = 1'b0;
        pick  = 3'd0;
        for (int c = 0; c < 8 && !acc; c++) begin
            chk("pick_mole", 32'(o_Mole), 32'h0);
            chk("pick_busy", 32'(o_Busy), 32'h1);
            chk("pick_score", 32'(o_Score), 32'(m_score));
            if (rmode == 0) r = rhold;
            else if ($urandom_range(0, 1) == 1) r = m_last;
            else r = 3'($urandom_range(0, 7));
            i_Rand = r;
            if (m_first || r != m_last) begin
                pick = r;
                acc  = 1'b1;
            end else if (retry == MAX_RETRY) begin
                pick = 3'((int'(m_last) + 1) % 8);
                acc  = 1'b1;
            end else begin
                retry++;
            end
            tick();
        end
        m_last  = pick;
        m_first = 1'b0;
        mole_x  = 8'h01 << pick;

        case (pkind)
            1: hv = mole_x;
            2: begin
                hv = 8'($urandom_range(1, 255)) & ~mole_x;
                if (hv == 8'h00) hv = 8'h01 << ((int'(pick) + 1) % 8);
            end
            3: hv = mole_x | 8'($urandom());
            4: hv = pval;
            default: hv = 8'h00;
        endcase

        outcome = 1'b0;
        was_hit = 1'b0;
        for (int c = 1; c <= SHOW_CYCLES && !outcome; c++) begin
            chk("show_mole", 32'(o_Mole), 32'(mole_x));
            chk("show_hitp", 32'(o_Hit_Pulse), 32'h0);
            chk("show_missp", 32'(o_Miss_Pulse), 32'h0);
            chk("show_misses", 32'(o_Misses), 32'(m_misses));
            i_Hit   = (pkind != 0 && c == pcyc) ? hv : 8'h00;
            i_Start = ($urandom_range(0, 3) == 0);
            if ((i_Hit & mole_x) != 8'h00) begin
                outcome = 1'b1;
                was_hit = 1'b1;
            end else if (i_Hit != 8'h00 || c == SHOW_CYCLES) begin
                outcome = 1'b1;
            end
            tick();
        end
        if (was_hit) m_score = (m_score < 31) ? m_score + 1 : 31;
        else m_misses = (m_misses < 31) ? m_misses + 1 : 31;

        for (int g = 0; g < GAP_CYCLES; g++) begin
            chk("gap_mole", 32'(o_Mole), 32'h0);
            chk("gap_hitp", 32'(o_Hit_Pulse), 32'((g == 0) && was_hit));
            chk("gap_missp", 32'(o_Miss_Pulse), 32'((g == 0) && !was_hit));
            chk("gap_score", 32'(o_Score), 32'(m_score));
            chk("gap_misses", 32'(o_Misses), 32'(m_misses));
            chk("gap_busy", 32'(o_Busy), 32'h1);
            i_Hit   = 8'($urandom());
            i_Start = ($urandom_range(0, 3) == 0);
            tick();
        end
        i_Hit   = 8'h00;
        i_Start = 1'b0;

        if (is_last) begin
            chk("done_state_done", 32'(o_Done), 32'h0);
            chk("done_state_busy", 32'(o_Busy), 32'h1);
            chk("done_state_mole", 32'(o_Mole), 32'h0);
            tick();
            chk("done_pulse", 32'(o_Done), 32'h1);
            chk("done_busy_fall", 32'(o_Busy), 32'h0);
            tick();
            chk("done_after", 32'(o_Done), 32'h0);
            chk("idle_busy", 32'(o_Busy), 32'h0);
        end
    endtask

    task automatic idle_hold(input int n);
        for (int k = 0; k < n; k++) begin
            chk("idle_score", 32'(o_Score), 32'(m_score));
            chk("idle_misses", 32'(o_Misses), 32'(m_misses));
            chk("idle_busy_k", 32'(o_Busy), 32'h0);
            chk("idle_mole", 32'(o_Mole), 32'h0);
            i_Rand = 3'($urandom_range(0, 7));
            i_Hit  = 8'($urandom());
            tick();
        end
        i_Hit = 8'h00;
    endtask

    initial begin
        rst_n    = 1'b0;
        i_Start  = 1'b0;
        i_Rand   = 3'd0;
        i_Hit    = 8'h00;
        m_last   = 3'd0;
        m_first  = 1'b1;
        m_score  = 0;
        m_misses = 0;
        tick();
        tick();
        chk_all_zero("reset");
        rst_n = 1'b1;
        tick();
        idle_hold(3);

        // Game 1: hit on cycle 3, forced 6 with timeout, wrong button, correct hit
        start_game();
        do_round(0, 3'd5, 4, 3, 8'h20, 1'b0);
        chk("g1_score1", 32'(o_Score), 32'd1);
        do_round(0, 3'd5, 0, 0, 8'h00, 1'b0);
        chk("g1_forced_last", 32'(m_last), 32'd6);
        do_round(0, 3'd5, 4, 1, 8'h01, 1'b0);
        chk("g1_misses2", 32'(o_Misses), 32'd2);
        do_round(0, 3'd7, 1, $urandom_range(1, 8), 8'h00, 1'b1);
        idle_hold(5);
        chk("g1_final_score", 32'(o_Score), 32'd2);

        // Game 2: first flag accepts repeat of 7, forced wrap to 0, hit on timeout cycle
        start_game();
        chk("g2_score_clear", 32'(o_Score), 32'd0);
        chk("g2_misses_clear", 32'(o_Misses), 32'd0);
        do_round(0, 3'd7, 2, 2, 8'h00, 1'b0);
        do_round(0, 3'd7, 1, 4, 8'h00, 1'b0);
        chk("g2_wrap_last", 32'(m_last), 32'd0);
        do_round(0, 3'd5, 4, 8, 8'h21, 1'b0);
        do_round(1, 3'd0, 3, $urandom_range(1, 8), 8'h00, 1'b1);
        idle_hold(2);

        // Game 3: all hits
        start_game();
        for (int rd = 0; rd < NUM_ROUNDS; rd++)
            do_round(1, 3'd0, 1, $urandom_range(1, 8), 8'h00, rd == NUM_ROUNDS - 1);
        chk("g3_all_hits", 32'(o_Score), 32'd4);
        idle_hold(2);

        // Randomized games
        for (int gm = 0; gm < 4; gm++) begin
            start_game();
            for (int rd = 0; rd < NUM_ROUNDS; rd++)
                do_round(1, 3'd0, $urandom_range(0, 3), $urandom_range(1, 8), 8'h00,
                         rd == NUM_ROUNDS - 1);
            idle_hold(2);
        end

        // Asynchronous reset in the middle of a lit mole
        start_game();
        do_round(0, 3'd2, 1, 2, 8'h00, 1'b0);
        do_round(0, 3'd4, 0, 0, 8'h00, 1'b0);
        i_Rand = 3'd6;
        tick();
        tick();
        chk("pre_rst_mole", 32'(o_Mole), 32'h40);
        chk("pre_rst_score", 32'(o_Score), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        tick();
        rst_n    = 1'b1;
        m_last   = 3'd0;
        m_first  = 1'b1;
        m_score  = 0;
        m_misses = 0;
        tick();
        idle_hold(6);
        chk_all_zero("post_rst");
        start_game();
        for (int rd = 0; rd < NUM_ROUNDS; rd++)
            do_round(1, 3'd0, $urandom_range(0, 3), $urandom_range(1, 8), 8'h00,
                     rd == NUM_ROUNDS - 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
